// File: rtl/pc_gen_if.sv
// PC generator bus: fetch handshake, redirect requests and status outputs.
// The master side is the PC generator; the slave side is the surrounding
// pipeline (fetch, execute and CSR unit).
interface pc_gen_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] inst_addr;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            halt_req;
  logic            halted;
  logic            misalign_err;
  logic [31:0]     fetch_cnt;

  modport master (
    output pc_valid, inst_addr, halted, misalign_err, fetch_cnt,
    input  pc_ready, br_valid, br_target, trap_valid, trap_target, halt_req
  );

  modport slave (
    input  pc_valid, inst_addr, halted, misalign_err, fetch_cnt,
    output pc_ready, br_valid, br_target, trap_valid, trap_target, halt_req
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator. Issues word-aligned PCs to the fetch stage with a
// valid/ready handshake, takes trap and branch redirects with one cycle of
// latency, and parks in HALT on a halt request until reset. Every output is
// driven straight from a register.
module pc_gen #(
  parameter int unsigned     XLEN          = 64,
  parameter logic [XLEN-1:0] PC_RESET_ADDR = 64'h8000_0000
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  // Clear the two low bits so a redirect always lands on a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    align_word = {addr[XLEN-1:2], 2'b00};
  endfunction

  // A target is misaligned when either low address bit is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    is_misaligned = |low_bits;
  endfunction

  logic [1:0]      state_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     fetch_cnt_r;
  logic            misalign_r;
  logic            pc_valid_r;
  logic            halted_r;

  logic [1:0]      state_nxt_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic            misalign_nxt_s;
  logic            fire_s;

  // Next-state and next-PC selection: halt > trap > branch > sequential > hold.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    misalign_nxt_s = 1'b0;
    fire_s         = pc_valid_r && bus.pc_ready;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          // Freeze the PC; any redirect in the same cycle is dropped.
          state_nxt_s = ST_HALT;
        end else if (bus.trap_valid) begin
          pc_nxt_s       = align_word(bus.trap_target);
          misalign_nxt_s = is_misaligned(bus.trap_target[1:0]);
        end else if (bus.br_valid) begin
          pc_nxt_s       = align_word(bus.br_target);
          misalign_nxt_s = is_misaligned(bus.br_target[1:0]);
        end else if (fire_s) begin
          pc_nxt_s = pc_r + PC_STEP;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, PC, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= PC_RESET_ADDR;
      fetch_cnt_r <= 32'd0;
      misalign_r  <= 1'b0;
      pc_valid_r  <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      misalign_r <= misalign_nxt_s;
      pc_valid_r <= (state_nxt_s == ST_RUN);
      halted_r   <= (state_nxt_s == ST_HALT);
      if (fire_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
    end
  end

  assign bus.inst_addr    = pc_r;
  assign bus.pc_valid     = pc_valid_r;
  assign bus.halted       = halted_r;
  assign bus.misalign_err = misalign_r;
  assign bus.fetch_cnt    = fetch_cnt_r;

endmodule
